// File: rtl/fsfifo_wr_arbiter.sv
// Round-robin arbiter sharing one fsfifo write port between N_REQ producers.
// The owner streams up to MAX_BURST beats, tagged with its ID, then re-arbitrates.
module fsfifo_wr_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int ID_BITS   = $clog2(N_REQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_o,
    output logic [ID_BITS+WIDTH-1:0] fifo_wr_data_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_BITS-1:0] LAST_ID   = ID_BITS'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE_HOT0  = N_REQ'(1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               r_state, w_state_nx;
    logic [ID_BITS-1:0]   r_owner, w_owner_nx;
    logic [ID_BITS-1:0]   r_last,  w_last_nx;
    logic [CNT_W-1:0]     r_cnt,   w_cnt_nx;
    logic [ID_BITS-1:0]   w_sel;
    logic                 w_found;
    logic                 w_busy;
    logic                 w_own_valid;
    logic [WIDTH-1:0]     w_own_data;

    // Descending scan so the nearest requester after r_last overwrites farther ones.
    always_comb begin
        logic [ID_BITS-1:0] idx;
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = ID_BITS'((int'(r_last) + int'(k)) % N_REQ);
            if (req_valid_i[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_busy      = (r_state == BURST);
    assign w_own_valid = req_valid_i[r_owner];
    assign w_own_data  = req_data_i[r_owner*WIDTH +: WIDTH];

    always_comb begin
        grant_o        = '0;
        req_ready_o    = '0;
        fifo_wr_o      = 1'b0;
        fifo_wr_data_o = '0;
        busy_o         = w_busy;
        if (w_busy) begin
            grant_o = ONE_HOT0 << r_owner;
            if (!fifo_full_i) begin
                req_ready_o = ONE_HOT0 << r_owner;
            end
            fifo_wr_o = w_own_valid && !fifo_full_i;
            if (fifo_wr_o) begin
                fifo_wr_data_o = {r_owner, w_own_data};
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx = BURST;
                    w_owner_nx = w_sel;
                    w_cnt_nx   = '0;
                end
            end
            BURST: begin
                if (!w_own_valid) begin
                    w_state_nx = IDLE;
                    w_last_nx  = r_owner;
                    w_cnt_nx   = '0;
                end else if (!fifo_full_i) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nx = IDLE;
                        w_last_nx  = r_owner;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= LAST_ID;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

endmodule

// File: tb/tb_fsfifo_wr_arbiter.sv
// Bench for fsfifo_wr_arbiter: two instances (MAX_BURST 4 and 3) checked every cycle
// against a grant/beat-budget model, a per-ID payload-order scoreboard and directed scenarios.
module tb_fsfifo_wr_arbiter;

    localparam int W = 16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  valid [2];
    logic [63:0] data  [2];
    logic        full  [2];
    logic [3:0]  ready [2];
    logic [3:0]  grant [2];
    logic        wr    [2];
    logic        busy  [2];
    logic [17:0] wd    [2];

    fsfifo_wr_arbiter #(.N_REQ(4), .WIDTH(W), .MAX_BURST(4)) dut4 (
        .clk_i(clk), .reset_ni(rst_n), .req_valid_i(valid[0]), .req_data_i(data[0]),
        .req_ready_o(ready[0]), .fifo_full_i(full[0]), .fifo_wr_o(wr[0]),
        .fifo_wr_data_o(wd[0]), .grant_o(grant[0]), .busy_o(busy[0]));

    fsfifo_wr_arbiter #(.N_REQ(4), .WIDTH(W), .MAX_BURST(3)) dut3 (
        .clk_i(clk), .reset_ni(rst_n), .req_valid_i(valid[1]), .req_data_i(data[1]),
        .req_ready_o(ready[1]), .fifo_full_i(full[1]), .fifo_wr_o(wr[1]),
        .fifo_wr_data_o(wd[1]), .grant_o(grant[1]), .busy_o(busy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit rnd  = 0;

    // model: current owner (-1 = none), beats used in this grant, last owner
    int mo [2] = '{-1, -1};
    int mu [2] = '{0, 0};
    int ml [2] = '{3, 3};
    int maxb [2] = '{4, 3};

    int rem  [2][4];
    int seq  [2][4];
    int wcnt [2][4];
    int runlen [2];
    logic [3:0] xf [2];
    logic [3:0] prevg [2];

    int wtag[$];
    int wdat[$];
    int wcyc[$];
    int gval[$];
    int gcyc[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    logic       eb, ew;
    logic [3:0] eg, er;
    logic [17:0] ed;
    int          tg;
    bit          fnd;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mo[i] = -1; mu[i] = 0; ml[i] = 3;
            end
            eb = (mo[i] >= 0);
            eg = '0; ew = 1'b0; ed = '0;
            if (eb) begin
                eg = 4'(1 << mo[i]);
                ew = valid[i][mo[i]] && !full[i];
                if (ew) ed = {2'(mo[i]), data[i][mo[i]*W +: W]};
            end
            er = (eb && !full[i]) ? eg : 4'b0;
            chk("grant_o", 64'(grant[i]), 64'(eg));
            chk("busy_o", 64'(busy[i]), 64'(eb));
            chk("req_ready_o", 64'(ready[i]), 64'(er));
            chk("fifo_wr_o", 64'(wr[i]), 64'(ew));
            chk("fifo_wr_data_o", 64'(wd[i]), 64'(ed));
            chk("grant_onehot0", 64'($onehot0(grant[i])), 64'(1));
            xf[i] = ew ? eg : 4'b0;

            if (grant[i] != prevg[i]) runlen[i] = 0;
            if (wr[i] === 1'b1) begin
                tg = int'(wd[i][17:16]);
                runlen[i]++;
                chk("burst_len_ok", 64'(runlen[i] <= maxb[i]), 64'(1));
                chk("payload_order", 64'(wd[i][15:0]), 64'(16'(tg * 4096 + wcnt[i][tg])));
                wcnt[i][tg]++;
                if (i == 0) begin
                    wtag.push_back(tg);
                    wdat.push_back(int'(wd[i][15:0]));
                    wcyc.push_back(cyc);
                end
            end
            if (i == 0 && grant[0] != 4'b0 && prevg[0] == 4'b0) begin
                gval.push_back(int'(grant[0]));
                gcyc.push_back(cyc);
            end
            prevg[i] = grant[i];

            if (rst_n) begin
                if (mo[i] < 0) begin
                    fnd = 0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!fnd && valid[i][(ml[i] + k) % 4]) begin
                            fnd = 1; mo[i] = (ml[i] + k) % 4; mu[i] = 0;
                        end
                    end
                end else if (!valid[i][mo[i]]) begin
                    ml[i] = mo[i]; mo[i] = -1;
                end else if (!full[i]) begin
                    mu[i]++;
                    if (mu[i] == maxb[i]) begin
                        ml[i] = mo[i]; mo[i] = -1;
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 4; r++) begin
                valid[i][r] = (rem[i][r] != 0);
                data[i][r*W +: W] = 16'(r * 4096 + seq[i][r]);
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 4; r++) begin
                if (xf[i][r]) begin
                    seq[i][r]++;
                    rem[i][r]--;
                end
                if (rnd && rem[i][r] == 0 && $urandom_range(3) == 0)
                    rem[i][r] = int'($urandom_range(5, 1));
            end
            if (rnd) full[i] = ($urandom_range(3) == 0);
        end
        drive();
        #1;
    endtask

    function automatic bit pending();
        for (int r = 0; r < 4; r++) if (rem[0][r] != 0) return 1;
        return 0;
    endfunction

    task automatic drain(input int maxc);
        int k = 0;
        while (pending() && k < maxc) begin
            step();
            k++;
        end
        chk("drain_within_bound", 64'(k < maxc), 64'(1));
        repeat (4) step();
    endtask

    task automatic clear_logs();
        wtag.delete(); wdat.delete(); wcyc.delete(); gval.delete(); gcyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    int base;
    int k;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            full[i] = 1'b0; xf[i] = '0; prevg[i] = '0; runlen[i] = 0;
            for (int r = 0; r < 4; r++) begin
                rem[i][r] = 0; seq[i][r] = 0; wcnt[i][r] = 0;
            end
        end
        drive();
        repeat (2) step();
        #1;
        chk("reset_grant", 64'(grant[0]), 64'(0));
        chk("reset_wr_data", 64'(wd[0]), 64'(0));
        rst_n = 1'b1;
        clear_logs();

        // single requester 2, six beats: 4 + 2 with one idle cycle between grants
        rem[0][2] = 6; drive();
        drain(40);
        chk("t1_nwrites", 64'(wtag.size()), 64'(6));
        chk("t1_ngrants", 64'(gval.size()), 64'(2));
        for (int j = 0; j < 6 && j < wtag.size(); j++) begin
            chk("t1_tag", 64'(wtag[j]), 64'(2));
            chk("t1_data", 64'(wdat[j]), 64'(2 * 4096 + j));
        end
        if (gval.size() == 2 && wcyc.size() == 6) begin
            chk("t1_grant0", 64'(gval[0]), 64'(4'b0100));
            chk("t1_b0_3_span", 64'(wcyc[3] - wcyc[0]), 64'(3));
            chk("t1_regrant_gap", 64'(wcyc[4] - wcyc[3]), 64'(2));
            chk("t1_regrant_cycle", 64'(gcyc[1]), 64'(wcyc[4]));
        end

        // all four continuously valid: 0,1,2,3,0,... each 4 beats, 5-cycle period
        do_reset();
        for (int r = 0; r < 4; r++) rem[0][r] = 8;
        drive();
        drain(100);
        chk("t2_nwrites", 64'(wtag.size()), 64'(32));
        chk("t2_ngrants", 64'(gval.size()), 64'(8));
        for (int j = 0; j < 8 && j < gval.size(); j++)
            chk("t2_grant_order", 64'(gval[j]), 64'(1 << (j % 4)));
        for (int j = 0; j + 1 < gcyc.size(); j++)
            chk("t2_period", 64'(gcyc[j+1] - gcyc[j]), 64'(5));
        for (int j = 0; j < 32 && j < wtag.size(); j++)
            chk("t2_tag", 64'(wtag[j]), 64'((j / 4) % 4));

        // requester 1 stalled by full for 3 cycles after its 2nd beat
        clear_logs();
        base = seq[0][1];
        rem[0][1] = 4; drive();
        k = 0;
        while (wtag.size() < 2 && k < 20) begin step(); k++; end
        chk("t3_reach_beat2", 64'(k < 20), 64'(1));
        full[0] = 1'b1;
        repeat (3) begin
            #1;
            chk("t3_ready_stalled", 64'(ready[0]), 64'(0));
            chk("t3_wr_stalled", 64'(wr[0]), 64'(0));
            chk("t3_grant_held", 64'(grant[0]), 64'(4'b0010));
            step();
        end
        full[0] = 1'b0;
        drain(30);
        chk("t3_nwrites", 64'(wtag.size()), 64'(4));
        for (int j = 0; j < 4 && j < wdat.size(); j++)
            chk("t3_data", 64'(wdat[j]), 64'(4096 + base + j));
        if (wcyc.size() == 4) chk("t3_stall_gap", 64'(wcyc[2] - wcyc[1]), 64'(4));

        // owner 0 drops after 1 beat with 3 waiting; 0 re-requests and follows 3
        do_reset();
        rem[0][0] = 1; rem[0][3] = 2; drive();
        k = 0;
        while (gval.size() < 2 && k < 20) begin step(); k++; end
        rem[0][0] = 2; drive();
        drain(40);
        chk("t4_ngrants", 64'(gval.size()), 64'(3));
        if (gval.size() == 3) begin
            chk("t4_g0", 64'(gval[0]), 64'(4'b0001));
            chk("t4_g1", 64'(gval[1]), 64'(4'b1000));
            chk("t4_g2", 64'(gval[2]), 64'(4'b0001));
        end
        chk("t4_nwrites", 64'(wtag.size()), 64'(5));

        // reset mid-burst (owner 2 after 2 beats); requester 0 wins afterwards
        do_reset();
        rem[0][2] = 4; drive();
        k = 0;
        while (wtag.size() < 2 && k < 20) begin step(); k++; end
        chk("t5_reach_beat2", 64'(k < 20), 64'(1));
        #1;
        chk("t5_wr_before", 64'(wr[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_grant_async", 64'(grant[0]), 64'(0));
        chk("t5_busy_async", 64'(busy[0]), 64'(0));
        chk("t5_wr_async", 64'(wr[0]), 64'(0));
        chk("t5_ready_async", 64'(ready[0]), 64'(0));
        clear_logs();
        rem[0][0] = 3; drive();
        step();
        rst_n = 1'b1;
        drain(40);
        chk("t5_ngrants", 64'(gval.size()), 64'(2));
        if (gval.size() == 2) begin
            chk("t5_first_grant", 64'(gval[0]), 64'(4'b0001));
            chk("t5_second_grant", 64'(gval[1]), 64'(4'b0100));
        end
        chk("t5_nwrites", 64'(wtag.size()), 64'(5));

        // random valid/full traffic on both instances
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        for (int i = 0; i < 2; i++) begin
            full[i] = 1'b0;
            for (int r = 0; r < 4; r++) rem[i][r] = 0;
        end
        drive();
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
